// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller, datapath muxes and ALU-control decoder.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WRITE,
        S_MEM_WB,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_BRANCH,
        S_ILLEGAL
    } state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic PCSRC_ALU    = 1'b0;
    localparam logic PCSRC_ALUOUT = 1'b1;

    // aluOp is looked ahead from the next state so the registered ALU-control
    // decoder already holds the right code while that state is active.
    function automatic logic [1:0] aluop_for(input state_e s);
        case (s)
            S_EXEC_R: return ALUOP_RTYPE;
            S_EXEC_I: return ALUOP_ITYPE;
            S_BRANCH: return ALUOP_BRANCH;
            default:  return ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_instret_counter.sv
// Retired-instruction counter: 32-bit, synchronous clear, increment enable, wraps.
module instret_counter (
    input  logic        clk,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (clr_i)
            count_q <= '0;
        else if (inc_i)
            count_q <= count_q + 32'd1;
    end

    assign count_o = count_q;

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle RISC-V-style datapath (load/store, ALU, beq/bne).
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        zero,
    input  logic        memReady,
    output logic [1:0]  aluOp,
    output logic        pcWrite,
    output logic        irWrite,
    output logic        regWrite,
    output logic        memRead,
    output logic        memWrite,
    output logic        iorD,
    output logic        memToReg,
    output logic [1:0]  aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic        pcSource,
    output logic        illegal,
    output logic [31:0] instret
);

    state_e state_q, state_d;
    logic   pc_we, ir_we, reg_we, mem_re, mem_we;
    logic   retire;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     state_d = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OPC_LOAD, OPC_STORE: state_d = S_MEM_ADDR;
                    OPC_OP:              state_d = S_EXEC_R;
                    OPC_OP_IMM:          state_d = S_EXEC_I;
                    OPC_BRANCH:          state_d = (funct3 == F3_BEQ || funct3 == F3_BNE)
                                                   ? S_BRANCH : S_ILLEGAL;
                    default:             state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OPC_STORE) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = memReady ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = memReady ? S_FETCH : S_MEM_WRITE;
            S_MEM_WB:    state_d = S_FETCH;
            S_EXEC_R:    state_d = S_ALU_WB;
            S_EXEC_I:    state_d = S_ALU_WB;
            S_ALU_WB:    state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_ILLEGAL:   state_d = S_ILLEGAL;
            default:     state_d = S_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        reg_we   = 1'b0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        iorD     = 1'b0;
        memToReg = 1'b0;
        aluSrcA  = SRCA_PC;
        aluSrcB  = SRCB_RS2;
        pcSource = PCSRC_ALU;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_re  = 1'b1;
                aluSrcB = SRCB_FOUR;
                pc_we   = memReady;
                ir_we   = memReady;
            end
            S_DECODE: begin
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_IMM;
            end
            S_MEM_ADDR: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_IMM;
            end
            S_MEM_READ: begin
                iorD   = 1'b1;
                mem_re = 1'b1;
            end
            S_MEM_WRITE: begin
                iorD   = 1'b1;
                mem_we = 1'b1;
            end
            S_MEM_WB: begin
                reg_we   = 1'b1;
                memToReg = 1'b1;
            end
            S_EXEC_R: aluSrcA = SRCA_RS1;
            S_EXEC_I: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_IMM;
            end
            S_ALU_WB: reg_we = 1'b1;
            S_BRANCH: begin
                aluSrcA  = SRCA_RS1;
                pcSource = PCSRC_ALUOUT;
                pc_we    = (funct3 == F3_BEQ) ? zero : ~zero;
            end
            S_ILLEGAL: illegal = 1'b1;
            default:   illegal = 1'b1;
        endcase
    end

    // Reset suppresses every write/access strobe immediately, not one edge later.
    assign pcWrite  = pc_we  & ~reset;
    assign irWrite  = ir_we  & ~reset;
    assign regWrite = reg_we & ~reset;
    assign memRead  = mem_re & ~reset;
    assign memWrite = mem_we & ~reset;

    assign aluOp = aluop_for(state_d);

    assign retire = ~reset && (state_d == S_FETCH) &&
                    (state_q == S_MEM_WRITE || state_q == S_MEM_WB ||
                     state_q == S_ALU_WB    || state_q == S_BRANCH);

    instret_counter u_instret (
        .clk     (clk),
        .clr_i   (reset),
        .inc_i   (retire),
        .count_o (instret)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        zero;
    logic        memReady;
    logic [1:0]  aluOp;
    logic        pcWrite, irWrite, regWrite, memRead, memWrite;
    logic        iorD, memToReg, pcSource, illegal;
    logic [1:0]  aluSrcA, aluSrcB;
    logic [31:0] instret;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
        .memReady(memReady), .aluOp(aluOp), .pcWrite(pcWrite), .irWrite(irWrite),
        .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite), .iorD(iorD),
        .memToReg(memToReg), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSource(pcSource),
        .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] L  = 7'b0000011;
    localparam logic [6:0] S  = 7'b0100011;
    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] I  = 7'b0010011;
    localparam logic [6:0] B  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;
    localparam logic [14:0] EN_MASK = 15'h1F00;

    typedef struct {
        string       name;
        logic [14:0] out;
        logic [14:0] mask;
        logic [31:0] ir;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // {aluOp, pcWrite, irWrite, regWrite, memRead, memWrite, iorD, memToReg, aluSrcA, aluSrcB, pcSource, illegal}
    function automatic logic [14:0] ctl(input string st, input logic mr, input logic pcw, input logic [1:0] aop);
        logic pw = 0, iw = 0, rw = 0, mrd = 0, mwr = 0, io = 0, m2r = 0, ps = 0, il = 0;
        logic [1:0] a = 2'b00, b = 2'b00;
        case (st)
            "FETCH":     begin mrd = 1; b = 2'b01; pw = pcw; iw = mr; end
            "DECODE":    begin a = 2'b01; b = 2'b10; end
            "MEM_ADDR":  begin a = 2'b10; b = 2'b10; end
            "MEM_READ":  begin io = 1; mrd = 1; end
            "MEM_WRITE": begin io = 1; mwr = 1; end
            "MEM_WB":    begin rw = 1; m2r = 1; end
            "EXEC_R":    begin a = 2'b10; b = 2'b00; end
            "EXEC_I":    begin a = 2'b10; b = 2'b10; end
            "ALU_WB":    rw = 1;
            "BRANCH":    begin a = 2'b10; b = 2'b00; ps = 1; pw = pcw; end
            "ILLEGAL":   il = 1;
            default:     ;
        endcase
        return {aop, pw, iw, rw, mrd, mwr, io, m2r, a, b, ps, il};
    endfunction

    task automatic step(input string st, input logic [6:0] op, input logic [2:0] f3,
                        input logic z, input logic mr, input logic rs,
                        input logic pcw, input logic [1:0] aop, input logic [31:0] ir);
        exp_t e;
        @(posedge clk);
        #1;
        opcode = op; funct3 = f3; zero = z; memReady = mr; reset = rs;
        e.name = rs ? "RESET" : st;
        e.out  = rs ? 15'h0 : ctl(st, mr, pcw, aop);
        e.mask = rs ? EN_MASK : 15'h7FFF;
        e.ir   = ir;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [14:0] got;
            e = q.pop_front();
            got = {aluOp, pcWrite, irWrite, regWrite, memRead, memWrite, iorD, memToReg,
                   aluSrcA, aluSrcB, pcSource, illegal};
            n_cmp++;
            if ((got & e.mask) !== (e.out & e.mask)) begin
                n_err++;
                $display("FAIL ctl[%s] t=%0t got=%015b want=%015b mask=%015b",
                         e.name, $time, got, e.out, e.mask);
            end
            n_cmp++;
            if (instret !== e.ir) begin
                n_err++;
                $display("FAIL instret[%s] t=%0t got=%08h want=%08h", e.name, $time, instret, e.ir);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; opcode = L; funct3 = 0; zero = 0; memReady = 1;
        @(posedge clk);
        step("RST", L, 0, 0, 1, 1, 0, 2'b00, 0);
        // load, no stalls
        step("FETCH",    L, 0, 0, 1, 0, 1, 2'b00, 0);
        step("DECODE",   L, 0, 0, 0, 0, 0, 2'b00, 0);
        step("MEM_ADDR", L, 0, 0, 1, 0, 0, 2'b00, 0);
        step("MEM_READ", L, 0, 0, 1, 0, 0, 2'b00, 0);
        step("MEM_WB",   L, 0, 0, 0, 0, 0, 2'b00, 0);
        // store with fetch stall and three write stalls
        step("FETCH",    S, 0, 0, 0, 0, 0, 2'b00, 1);
        step("FETCH",    S, 0, 0, 1, 0, 1, 2'b00, 1);
        step("DECODE",   S, 0, 0, 1, 0, 0, 2'b00, 1);
        step("MEM_ADDR", S, 0, 0, 1, 0, 0, 2'b00, 1);
        for (int k = 0; k < 3; k++) step("MEM_WRITE", S, 0, 0, 0, 0, 0, 2'b00, 1);
        step("MEM_WRITE", S, 0, 0, 1, 0, 0, 2'b00, 1);
        // R-type; memReady toggled in non-memory states
        step("FETCH",  R, 0, 0, 1, 0, 1, 2'b00, 2);
        step("DECODE", R, 0, 0, 0, 0, 0, 2'b10, 2);
        step("EXEC_R", R, 0, 0, 1, 0, 0, 2'b00, 2);
        step("ALU_WB", R, 0, 0, 1, 0, 0, 2'b00, 2);
        // I-type
        step("FETCH",  I, 0, 0, 1, 0, 1, 2'b00, 3);
        step("DECODE", I, 0, 0, 1, 0, 0, 2'b11, 3);
        step("EXEC_I", I, 0, 0, 1, 0, 0, 2'b00, 3);
        step("ALU_WB", I, 0, 0, 1, 0, 0, 2'b00, 3);
        // beq taken / not taken, bne taken / not taken
        step("FETCH",  B, 0, 0, 1, 0, 1, 2'b00, 4);
        step("DECODE", B, 0, 0, 1, 0, 0, 2'b01, 4);
        step("BRANCH", B, 0, 1, 1, 0, 1, 2'b00, 4);
        step("FETCH",  B, 0, 1, 1, 0, 1, 2'b00, 5);
        step("DECODE", B, 0, 1, 1, 0, 0, 2'b01, 5);
        step("BRANCH", B, 0, 0, 1, 0, 0, 2'b00, 5);
        step("FETCH",  B, 1, 0, 1, 0, 1, 2'b00, 6);
        step("DECODE", B, 1, 0, 1, 0, 0, 2'b01, 6);
        step("BRANCH", B, 1, 0, 1, 0, 1, 2'b00, 6);
        step("FETCH",  B, 1, 1, 1, 0, 1, 2'b00, 7);
        step("DECODE", B, 1, 1, 1, 0, 0, 2'b01, 7);
        step("BRANCH", B, 1, 1, 1, 0, 0, 2'b00, 7);
        // unsupported opcode: absorbing ILLEGAL, then reset recovers
        step("FETCH",  BAD, 0, 0, 1, 0, 1, 2'b00, 8);
        step("DECODE", BAD, 0, 0, 1, 0, 0, 2'b00, 8);
        for (int k = 0; k < 10; k++) step("ILLEGAL", L, 0, 1, 1, 0, 0, 2'b00, 8);
        step("RST",    L, 0, 0, 1, 1, 0, 2'b00, 8);
        step("FETCH",  L, 0, 0, 0, 0, 0, 2'b00, 0);
        // branch with funct3=010 is illegal
        step("FETCH",   B, 2, 0, 1, 0, 1, 2'b00, 0);
        step("DECODE",  B, 2, 0, 1, 0, 0, 2'b00, 0);
        step("ILLEGAL", B, 2, 0, 1, 0, 0, 2'b00, 0);
        step("ILLEGAL", R, 0, 0, 1, 0, 0, 2'b00, 0);
        step("RST",     R, 0, 0, 1, 1, 0, 2'b00, 0);
        step("FETCH",   R, 0, 0, 1, 0, 1, 2'b00, 0);
        step("DECODE",  R, 0, 0, 1, 0, 0, 2'b10, 0);
        step("EXEC_R",  R, 0, 0, 1, 0, 0, 2'b00, 0);
        step("ALU_WB",  R, 0, 0, 1, 0, 0, 2'b00, 0);
        // reset during a stalled MEM_READ
        step("FETCH",    L, 0, 0, 1, 0, 1, 2'b00, 1);
        step("DECODE",   L, 0, 0, 1, 0, 0, 2'b00, 1);
        step("MEM_ADDR", L, 0, 0, 1, 0, 0, 2'b00, 1);
        step("MEM_READ", L, 0, 0, 0, 0, 0, 2'b00, 1);
        step("MEM_READ", L, 0, 0, 0, 0, 0, 2'b00, 1);
        step("RST",      L, 0, 0, 0, 1, 0, 2'b00, 1);
        step("FETCH",    R, 0, 0, 0, 0, 0, 2'b00, 0);
        // preload the counter to all-ones while FETCH stalls, then retire one ALU op
        step("FETCH",    R, 0, 0, 0, 0, 0, 2'b00, 32'hFFFF_FFFF);
        force dut.u_instret.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_instret.count_q;
        step("FETCH",  R, 0, 0, 1, 0, 1, 2'b00, 32'hFFFF_FFFF);
        step("DECODE", R, 0, 0, 1, 0, 0, 2'b10, 32'hFFFF_FFFF);
        step("EXEC_R", R, 0, 0, 1, 0, 0, 2'b00, 32'hFFFF_FFFF);
        step("ALU_WB", R, 0, 0, 1, 0, 0, 2'b00, 32'hFFFF_FFFF);
        step("FETCH",  R, 0, 0, 0, 0, 0, 2'b00, 0);
        repeat (3) @(posedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 opcode  in  7  instruction-register opcode, stable from DECODE until instruction completion.
REQ-004 funct3  in  3  instruction-register funct3, for branch condition and legality.
REQ-005 zero  in  1  ALU zero flag, sampled in BRANCH.
REQ-006 memReady  in  1  memory handshake: access completes in any cycle with memRead or memWrite high and memReady=1.
REQ-007 aluOp  out  2  ALU-control class: 00 add, 01 branch compare, 10 R-type, 11 I-type.
REQ-008 pcWrite, irWrite, regWrite, memRead, memWrite  out  1 each  datapath enables.
REQ-009 iorD  out  1  memory address select: 0 PC, 1 ALUOut.
REQ-010 memToReg  out  1  write-back select: 0 ALUOut, 1 memory data.
REQ-011 aluSrcA  out  2  00 PC, 01 oldPC, 10 rs1.
REQ-012 aluSrcB  out  2  00 rs2, 01 constant 4, 10 immediate.
REQ-013 pcSource  out  1  0 ALU result, 1 ALUOut.
REQ-014 illegal  out  1  sticky unsupported-instruction flag.
REQ-015 instret  out  32  count of completed instructions.

Function
REQ-016 Opcodes: LOAD 0000011, STORE 0100011, OP 0110011, OP_IMM 0010011, BRANCH 1100011 (funct3 000 beq, 001 bne).
REQ-017 Moore FSM; enables and selects decode from the state register only; unlisted outputs are 0.
REQ-018 FETCH: iorD=0, memRead=1, aluSrcA=00, aluSrcB=01, pcSource=0; irWrite=pcWrite=memReady; next DECODE if memReady, else FETCH.
REQ-019 DECODE: aluSrcA=01, aluSrcB=10 (branch target into ALUOut); next MEM_ADDR for LOAD/STORE, EXEC_R for OP, EXEC_I for OP_IMM, BRANCH for BRANCH with funct3 000/001, else ILLEGAL.
REQ-020 MEM_ADDR: aluSrcA=10, aluSrcB=10; next MEM_READ for LOAD, MEM_WRITE for STORE.
REQ-021 MEM_READ: iorD=1, memRead=1; holds until memReady, then MEM_WB.
REQ-022 MEM_WRITE: iorD=1, memWrite=1; holds until memReady, then FETCH; memWrite stays high for every stall cycle.
REQ-023 MEM_WB: regWrite=1, memToReg=1; next FETCH.
REQ-024 EXEC_R: aluSrcA=10, aluSrcB=00; EXEC_I: aluSrcA=10, aluSrcB=10; both go to ALU_WB.
REQ-025 ALU_WB: regWrite=1, memToReg=0; next FETCH.
REQ-026 BRANCH: aluSrcA=10, aluSrcB=00, pcSource=1; pcWrite = zero for beq, ~zero for bne; next FETCH.
REQ-027 ILLEGAL: all enables 0, illegal=1; absorbing until reset.
REQ-028 aluOp is lookahead: a combinational function of next_state (EXEC_R→10, BRANCH→01, EXEC_I→11, otherwise 00), so the clocked downstream ALU-control decoder holds the correct code during the state itself.
REQ-029 instret increments by 1 on each transition into FETCH from MEM_WRITE, MEM_WB, ALU_WB or BRANCH; wraps from FFFFFFFF to 0; never increments in ILLEGAL.
REQ-030 memReady is ignored in states with no memory access.

Reset
REQ-031 Reset high at a rising edge: state=FETCH, instret=0, illegal=0, regardless of current state, including mid-stall.
REQ-032 While reset is high, pcWrite, irWrite, regWrite, memWrite and memRead are forced to 0 combinationally.
REQ-033 The first cycle after reset deasserts is FETCH.

Structure
REQ-034 Shared package holds the state enum, opcode constants, aluOp codes and aluSrcA/aluSrcB/pcSource encodings, so datapath and ALU-control can reuse them.
REQ-035 One sub-module, instret_counter (32-bit, synchronous clear, increment enable), is instantiated; all other logic stays in multicycle_control.

Verification
REQ-036 Load with memReady=1: states FETCH→DECODE→MEM_ADDR→MEM_READ→MEM_WB→FETCH; regWrite=1 with memToReg=1 only in MEM_WB; instret 0→1.
REQ-037 Store with memReady low for 3 cycles in MEM_WRITE: memWrite=1 for 4 cycles, then FETCH; regWrite never 1.
REQ-038 beq: zero=1 gives pcWrite=1 and pcSource=1 in BRANCH; zero=0 gives pcWrite=0. bne shows the inverse behaviour.
REQ-039 aluOp lookahead for an R-type: aluOp=10 in the DECODE cycle, 00 in EXEC_R; I-type gives 11 in DECODE; branch gives 01 in DECODE.
REQ-040 Opcode 1111111 or branch funct3=010: ILLEGAL, illegal=1, no enables over 10 further cycles; reset pulse gives FETCH with illegal=0.
REQ-041 Reset asserted during a stalled MEM_READ: next cycle is FETCH, instret=0; preloaded instret=FFFFFFFF plus one ALU instruction gives instret=0.
